// File: rtl/sized_data_ram_if.sv
// Request/response bundle for the sized big-endian data RAM.
// The initiator drives the request fields and the RAM returns the completion.
interface sized_data_ram_if;
  logic        req;
  logic        mWR;
  logic [1:0]  size;
  logic        signExt;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] Dataout;
  logic        ready;
  logic        busy;
  logic        fault;

  modport master (output req, mWR, size, signExt, address, writeData,
                  input  Dataout, ready, busy, fault);
  modport slave  (input  req, mWR, size, signExt, address, writeData,
                  output Dataout, ready, busy, fault);
endinterface

// File: rtl/sized_data_ram.sv
// Byte-addressed big-endian data RAM with byte/half/word access and programmable wait states.
// Illegal accesses complete in one cycle with fault set and never touch memory.
module sized_data_ram #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          CLK,
  input  logic          Reset,
  sized_data_ram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q;
  logic           wr_q, se_q;
  logic [1:0]     size_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    wd_q;
  logic [31:0]    dout_q;
  logic           ready_q, fault_q;

  logic [7:0]     mem [DEPTH];

  logic [32:0]    last;
  logic           illegal, accept, reject, commit;
  logic [7:0]     b0, b1, b2, b3;
  logic           sbit;
  logic [31:0]    ld_data;

  // Last byte touched is computed 33 bits wide so high addresses cannot wrap into range.
  always_comb begin
    last = {1'b0, bus.address} + ((bus.size == 2'b10) ? 33'd3 :
                                  (bus.size == 2'b01) ? 33'd1 : 33'd0);
    illegal = (bus.size == 2'b11)
           || (bus.size == 2'b01 && bus.address[0])
           || (bus.size == 2'b10 && bus.address[1:0] != 2'b00)
           || (last >= 33'(DEPTH));
  end

  assign accept = (state_q == IDLE) && bus.req && !illegal;
  assign reject = (state_q == IDLE) && bus.req &&  illegal;
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Legal accesses never cross the end of memory, so the modulo index only matters for unused lanes.
  always_comb begin
    b0   = mem[addr_q];
    b1   = mem[addr_q + AW'(1)];
    b2   = mem[addr_q + AW'(2)];
    b3   = mem[addr_q + AW'(3)];
    sbit = se_q & b0[7];
    case (size_q)
      2'b00:   ld_data = {{24{sbit}}, b0};
      2'b01:   ld_data = {{16{sbit}}, b0, b1};
      default: ld_data = {b0, b1, b2, b3};
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      se_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wd_q    <= 32'd0;
      dout_q  <= 32'd0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      if (accept) begin
        wr_q   <= bus.mWR;
        se_q   <= bus.signExt;
        size_q <= bus.size;
        addr_q <= bus.address[AW-1:0];
        wd_q   <= bus.writeData;
        cnt_q  <= 4'(WAIT_CYCLES);
      end else if (reject) begin
        ready_q <= 1'b1;
        fault_q <= 1'b1;
      end
      if (state_q == BUSY && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (commit) begin
        ready_q <= 1'b1;
        if (!wr_q) dout_q <= ld_data;
      end
    end
  end

  // Memory has no reset; an aborted access never reaches commit because state is forced IDLE.
  always_ff @(posedge CLK) begin
    if (commit && wr_q) begin
      case (size_q)
        2'b00: mem[addr_q] <= wd_q[7:0];
        2'b01: begin
          mem[addr_q]          <= wd_q[15:8];
          mem[addr_q + AW'(1)] <= wd_q[7:0];
        end
        2'b10: begin
          mem[addr_q]          <= wd_q[31:24];
          mem[addr_q + AW'(1)] <= wd_q[23:16];
          mem[addr_q + AW'(2)] <= wd_q[15:8];
          mem[addr_q + AW'(3)] <= wd_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.Dataout = dout_q;
  assign bus.ready   = ready_q;
  assign bus.fault   = fault_q;
  assign bus.busy    = (state_q == BUSY);
endmodule

// File: tb/tb_sized_data_ram.sv
// Directed bench: one RAM with no wait states, one with three, sharing clock and reset.
module tb_sized_data_ram;
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  sized_data_ram_if ia ();
  sized_data_ram_if ib ();

  sized_data_ram #(.DEPTH(256), .WAIT_CYCLES(0)) dut_a (.CLK(CLK), .Reset(Reset), .bus(ia.slave));
  sized_data_ram #(.DEPTH(256), .WAIT_CYCLES(3)) dut_b (.CLK(CLK), .Reset(Reset), .bus(ib.slave));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input bit which, input bit r, input bit wr, input logic [1:0] sz,
                       input bit se, input logic [31:0] ad, input logic [31:0] wd);
    if (which) begin
      ib.req = r; ib.mWR = wr; ib.size = sz; ib.signExt = se; ib.address = ad; ib.writeData = wd;
    end else begin
      ia.req = r; ia.mWR = wr; ia.size = sz; ia.signExt = se; ia.address = ad; ia.writeData = wd;
    end
  endtask

  task automatic set_req(input bit which, input bit r);
    if (which) ib.req = r; else ia.req = r;
  endtask

  function automatic logic rdy(input bit which);
    return which ? ib.ready : ia.ready;
  endfunction
  function automatic logic bsy(input bit which);
    return which ? ib.busy : ia.busy;
  endfunction
  function automatic logic flt_of(input bit which);
    return which ? ib.fault : ia.fault;
  endfunction
  function automatic logic [31:0] dout(input bit which);
    return which ? ib.Dataout : ia.Dataout;
  endfunction

  // Called #1 after an edge; req goes up at once, so consecutive calls are back-to-back.
  task automatic access(input bit which, input bit wr, input logic [1:0] sz, input bit se,
                        input logic [31:0] ad, input logic [31:0] wd, input bit poke,
                        output int lat, output logic flt, output bit busy_seen);
    drive(which, 1'b1, wr, sz, se, ad, wd);
    lat = 0; flt = 1'bx; busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (i == 0) set_req(which, 1'b0);
      if (poke && i == 1) drive(which, 1'b1, 1'b1, 2'b10, 1'b0, 32'h84, 32'hFFFF_FFFF);
      if (poke && i == 2) set_req(which, 1'b0);
      if (bsy(which)) busy_seen = 1'b1;
      if (rdy(which)) begin
        flt = flt_of(which);
        break;
      end
    end
  endtask

  int   lat;
  logic flt;
  bit   bs;
  bit   quiet;

  initial begin
    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    #12;
    chk("rst dout_a",  ia.Dataout, 32'h0);
    chk("rst ready_a", 32'(ia.ready), 32'h0);
    chk("rst busy_a",  32'(ia.busy), 32'h0);
    chk("rst fault_a", 32'(ia.fault), 32'h0);
    chk("rst busy_b",  32'(ib.busy), 32'h0);
    @(posedge CLK); #1 Reset = 1'b1;

    // No-wait-state RAM
    access(0, 1, 2'b10, 0, 32'h10, 32'h1122_3344, 0, lat, flt, bs);
    chk("a st_w lat", lat, 2);
    chk("a st_w fault", 32'(flt), 0);
    access(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, lat, flt, bs);
    chk("a ld_w lat", lat, 2);
    chk("a ld_w data", ia.Dataout, 32'h1122_3344);
    access(0, 0, 2'b00, 1, 32'h13, 32'h0, 0, lat, flt, bs);
    chk("a ld_b13 data", ia.Dataout, 32'h0000_0044);
    access(0, 1, 2'b00, 0, 32'h10, 32'h0000_00F0, 0, lat, flt, bs);
    chk("a st_b hold dout", ia.Dataout, 32'h0000_0044);
    access(0, 0, 2'b01, 1, 32'h10, 32'h0, 0, lat, flt, bs);
    chk("a ld_h sext", ia.Dataout, 32'hFFFF_F022);
    access(0, 0, 2'b01, 0, 32'h10, 32'h0, 0, lat, flt, bs);
    chk("a ld_h zext", ia.Dataout, 32'h0000_F022);
    access(0, 1, 2'b10, 0, 32'h20, 32'hAABB_CCDD, 0, lat, flt, bs);
    chk("a st_w20 fault", 32'(flt), 0);

    access(0, 1, 2'b01, 0, 32'h21, 32'h0000_BEEF, 0, lat, flt, bs);
    chk("a st_h odd lat", lat, 1);
    chk("a st_h odd fault", 32'(flt), 1);
    chk("a st_h odd busy", 32'(bs), 0);
    chk("a st_h odd dout", ia.Dataout, 32'h0000_F022);
    access(0, 0, 2'b10, 0, 32'h12, 32'h0, 0, lat, flt, bs);
    chk("a ld_w mis lat", lat, 1);
    chk("a ld_w mis fault", 32'(flt), 1);
    chk("a ld_w mis busy", 32'(bs), 0);
    chk("a ld_w mis dout", ia.Dataout, 32'h0000_F022);
    access(0, 0, 2'b11, 0, 32'h10, 32'h0, 0, lat, flt, bs);
    chk("a rsv size fault", 32'(flt), 1);

    access(0, 0, 2'b10, 0, 32'h20, 32'h0, 0, lat, flt, bs);
    chk("a ld_w20 intact", ia.Dataout, 32'hAABB_CCDD);
    access(0, 0, 2'b10, 1, 32'h10, 32'h0, 0, lat, flt, bs);
    chk("a ld_w10 se ignored", ia.Dataout, 32'hF022_3344);
    access(0, 0, 2'b00, 1, 32'h10, 32'h0, 0, lat, flt, bs);
    chk("a ld_b sext", ia.Dataout, 32'hFFFF_FFF0);
    access(0, 0, 2'b00, 0, 32'h10, 32'h0, 0, lat, flt, bs);
    chk("a ld_b zext", ia.Dataout, 32'h0000_00F0);

    // Three-wait-state RAM
    access(1, 1, 2'b10, 0, 32'hFC, 32'hCAFE_F00D, 0, lat, flt, bs);
    chk("b st_wFC lat", lat, 5);
    access(1, 0, 2'b10, 1, 32'hFC, 32'h0, 0, lat, flt, bs);
    chk("b ld_wFC lat", lat, 5);
    chk("b ld_wFC fault", 32'(flt), 0);
    chk("b ld_wFC busy", 32'(bs), 1);
    chk("b ld_wFC data", ib.Dataout, 32'hCAFE_F00D);
    access(1, 0, 2'b10, 0, 32'hFE, 32'h0, 0, lat, flt, bs);
    chk("b ld_wFE lat", lat, 1);
    chk("b ld_wFE fault", 32'(flt), 1);
    access(1, 0, 2'b01, 0, 32'hFE, 32'h0, 0, lat, flt, bs);
    chk("b ld_hFE fault", 32'(flt), 0);
    chk("b ld_hFE data", ib.Dataout, 32'h0000_F00D);
    access(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, lat, flt, bs);
    chk("b ld_w100 fault", 32'(flt), 1);

    access(1, 1, 2'b10, 0, 32'h84, 32'h0, 0, lat, flt, bs);
    access(1, 1, 2'b10, 0, 32'h80, 32'h1234_5678, 1, lat, flt, bs);
    chk("b poke lat", lat, 5);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (ib.ready || ib.busy) quiet = 1'b0;
    end
    chk("b poke not queued", 32'(quiet), 1);
    access(1, 0, 2'b10, 0, 32'h84, 32'h0, 0, lat, flt, bs);
    chk("b poke no write", ib.Dataout, 32'h0);
    access(1, 0, 2'b10, 0, 32'h80, 32'h0, 0, lat, flt, bs);
    chk("b ld_w80", ib.Dataout, 32'h1234_5678);
    access(1, 1, 2'b10, 0, 32'h40, 32'h0102_0304, 0, lat, flt, bs);
    chk("b st hold dout", ib.Dataout, 32'h1234_5678);

    drive(1, 1, 1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF);
    @(posedge CLK); #1 set_req(1, 0);
    chk("b abort busy", 32'(ib.busy), 1);
    @(posedge CLK); #2 Reset = 1'b0;
    #1;
    chk("b abort busy clr", 32'(ib.busy), 0);
    chk("b abort dout clr", ib.Dataout, 32'h0);
    chk("b abort ready clr", 32'(ib.ready), 0);
    chk("b abort fault clr", 32'(ib.fault), 0);
    @(posedge CLK); #1 Reset = 1'b1;
    access(1, 0, 2'b10, 0, 32'h40, 32'h0, 0, lat, flt, bs);
    chk("b post-abort lat", lat, 5);
    chk("b post-abort data", ib.Dataout, 32'h0102_0304);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
